// File: rtl/alarm_multi_if.sv
// alarm_multi_if: time, load, readback, user-request and LED signals of the multi-channel alarm.
interface alarm_multi_if #(
   parameter int NUM_ALARMS = 4,
   parameter int LED_WIDTH  = 9
);
   localparam int SEL_W = NUM_ALARMS > 1 ? $clog2(NUM_ALARMS) : 1;
   logic                  sec_tick;
   logic [3:0]            time_sec0, time_sec1, time_min0, time_min1;
   logic [NUM_ALARMS-1:0] alarm_en;
   logic                  load_en;
   logic [SEL_W-1:0]      load_sel;
   logic [3:0]            load_sec0, load_sec1, load_min0, load_min1;
   logic [SEL_W-1:0]      rd_sel;
   logic [3:0]            rd_sec0, rd_sec1, rd_min0, rd_min1;
   logic                  snooze, dismiss;
   logic [LED_WIDTH-1:0]  led;
   logic                  ringing, snoozing;
   logic [SEL_W-1:0]      active_idx;
   logic                  load_err;
   modport master (
      output sec_tick, time_sec0, time_sec1, time_min0, time_min1, alarm_en,
             load_en, load_sel, load_sec0, load_sec1, load_min0, load_min1,
             rd_sel, snooze, dismiss,
      input  rd_sec0, rd_sec1, rd_min0, rd_min1, led, ringing, snoozing,
             active_idx, load_err
   );
   modport slave (
      input  sec_tick, time_sec0, time_sec1, time_min0, time_min1, alarm_en,
             load_en, load_sel, load_sec0, load_sec1, load_min0, load_min1,
             rd_sel, snooze, dismiss,
      output rd_sec0, rd_sec1, rd_min0, rd_min1, led, ringing, snoozing,
             active_idx, load_err
   );
endinterface

// File: rtl/alarm_multi.sv
// alarm_multi: NUM_ALARMS BCD mm:ss alarm channels sharing one ring/snooze FSM that drives the LED bank.
module alarm_multi #(
   parameter int NUM_ALARMS  = 4,
   parameter int LED_WIDTH   = 9,
   parameter int RING_SECS   = 30,
   parameter int SNOOZE_SECS = 300
) (
   input logic          clk,
   input logic          rst_n,
   alarm_multi_if.slave bus
);
   localparam int SEL_W = NUM_ALARMS > 1 ? $clog2(NUM_ALARMS) : 1;
   localparam int RW    = $clog2(RING_SECS + 1);
   localparam int SW    = $clog2(SNOOZE_SECS + 1);

   typedef enum logic [1:0] {IDLE, RINGING, SNOOZE} state_e;

   state_e           state_q, state_d;
   logic [RW-1:0]    ring_cnt_q, ring_cnt_d;
   logic [SW-1:0]    snz_cnt_q, snz_cnt_d;
   logic             blink_q, blink_d;
   logic [SEL_W-1:0] active_idx_q, active_idx_d, hit_idx;
   logic             match_prev_q, any_match, load_ok, load_err_q;
   logic [15:0]      set_q [NUM_ALARMS];
   logic [15:0]      cur_time, load_val, rd_val;

   assign cur_time = {bus.time_min1, bus.time_min0, bus.time_sec1, bus.time_sec0};
   assign load_val = {bus.load_min1, bus.load_min0, bus.load_sec1, bus.load_sec0};
   assign load_ok  = 32'(bus.load_sel) < NUM_ALARMS && bus.load_min0 <= 4'd9 &&
                     bus.load_sec0 <= 4'd9 && bus.load_min1 <= 4'd5 && bus.load_sec1 <= 4'd5;
   assign rd_val   = 32'(bus.rd_sel) < NUM_ALARMS ? set_q[bus.rd_sel] : '0;
   assign {bus.rd_min1, bus.rd_min0, bus.rd_sec1, bus.rd_sec0} = rd_val;

   // Scan downwards so the lowest matching channel wins.
   always_comb begin
      any_match = 1'b0;
      hit_idx   = '0;
      for (int i = NUM_ALARMS - 1; i >= 0; i--)
         if (bus.alarm_en[i] && set_q[i] == cur_time) begin
            any_match = 1'b1;
            hit_idx   = SEL_W'(i);
         end
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         for (int i = 0; i < NUM_ALARMS; i++) set_q[i] <= '0;
         load_err_q <= 1'b0;
      end else begin
         if (bus.load_en && load_ok) set_q[bus.load_sel] <= load_val;
         load_err_q <= bus.load_en && !load_ok;
      end

   always_comb begin
      state_d      = state_q;
      ring_cnt_d   = ring_cnt_q;
      snz_cnt_d    = snz_cnt_q;
      blink_d      = blink_q;
      active_idx_d = active_idx_q;
      unique case (state_q)
         IDLE:
            if (any_match && !match_prev_q) begin
               state_d      = RINGING;
               active_idx_d = hit_idx;
               ring_cnt_d   = RW'(RING_SECS);
               blink_d      = 1'b1;
            end
         RINGING:
            if (bus.dismiss) state_d = IDLE;
            else if (bus.snooze) begin
               state_d   = SNOOZE;
               snz_cnt_d = SW'(SNOOZE_SECS);
            end else if (!bus.alarm_en[active_idx_q]) state_d = IDLE;
            else if (bus.sec_tick) begin
               ring_cnt_d = ring_cnt_q - RW'(1);
               blink_d    = !blink_q;
               if (ring_cnt_q == RW'(1)) state_d = IDLE;
            end
         SNOOZE:
            if (bus.dismiss || !bus.alarm_en[active_idx_q]) state_d = IDLE;
            else if (bus.sec_tick) begin
               snz_cnt_d = snz_cnt_q - SW'(1);
               if (snz_cnt_q == SW'(1)) begin
                  state_d    = RINGING;
                  ring_cnt_d = RW'(RING_SECS);
                  blink_d    = 1'b1;
               end
            end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q      <= IDLE;
         ring_cnt_q   <= '0;
         snz_cnt_q    <= '0;
         blink_q      <= 1'b0;
         active_idx_q <= '0;
         match_prev_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         ring_cnt_q   <= ring_cnt_d;
         snz_cnt_q    <= snz_cnt_d;
         blink_q      <= blink_d;
         active_idx_q <= active_idx_d;
         match_prev_q <= any_match;
      end

   assign bus.ringing    = state_q == RINGING;
   assign bus.snoozing   = state_q == SNOOZE;
   assign bus.led        = bus.ringing ? (blink_q ? '1 : '0) : (bus.snoozing ? LED_WIDTH'(1) : '0);
   assign bus.active_idx = active_idx_q;
   assign bus.load_err   = load_err_q;
endmodule

// File: tb/tb_alarm_multi.sv
// tb_alarm_multi: directed and random stimulus scored against a seconds-based reference model of the alarm.
module tb_alarm_multi;
   localparam int NA = 4, LW = 9, RS = 3, SS = 5;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alarm_multi_if #(.NUM_ALARMS(NA), .LED_WIDTH(LW)) bus ();
   alarm_multi #(.NUM_ALARMS(NA), .LED_WIDTH(LW), .RING_SECS(RS), .SNOOZE_SECS(SS))
      dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   typedef struct packed {
      logic          ringing;
      logic          snoozing;
      logic [LW-1:0] led;
      logic [1:0]    idx;
      logic          err;
      logic [15:0]   rd;
   } exp_t;

   exp_t sbq[$];
   exp_t me;
   int compared = 0, mismatched = 0;

   // Model: 0 idle, 1 ringing, 2 snoozing; settings and time kept as seconds past the hour.
   int mode, rcnt, scnt, aidx, cur;
   int set_s[NA];
   bit blink, prev, lerr;

   function automatic logic [15:0] bcd(int v);
      return {4'(v / 600), 4'((v / 60) % 10), 4'((v % 60) / 10), 4'(v % 10)};
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   always @(posedge clk) begin
      #2;
      if (sbq.size() > 0) begin
         me = sbq.pop_front();
         chk("ringing", 32'(bus.ringing), 32'(me.ringing));
         chk("snoozing", 32'(bus.snoozing), 32'(me.snoozing));
         chk("led", 32'(bus.led), 32'(me.led));
         chk("active_idx", 32'(bus.active_idx), 32'(me.idx));
         chk("load_err", 32'(bus.load_err), 32'(me.err));
         chk("readback", 32'({bus.rd_min1, bus.rd_min0, bus.rd_sec1, bus.rd_sec0}), 32'(me.rd));
      end
   end

   task automatic model_reset();
      mode = 0; rcnt = 0; scnt = 0; aidx = 0; blink = 0; prev = 0; lerr = 0;
      foreach (set_s[i]) set_s[i] = 0;
   endtask

   task automatic model_step();
      int hit = -1;
      int sel;
      bit trig, bad;
      for (int i = 0; i < NA; i++)
         if (hit < 0 && bus.alarm_en[i] && set_s[i] == cur) hit = i;
      trig = hit >= 0 && !prev;
      prev = hit >= 0;
      case (mode)
         0: if (trig) begin mode = 1; aidx = hit; rcnt = RS; blink = 1; end
         1: if (bus.dismiss) mode = 0;
            else if (bus.snooze) begin mode = 2; scnt = SS; end
            else if (!bus.alarm_en[aidx]) mode = 0;
            else if (bus.sec_tick) begin
               rcnt--; blink = !blink;
               if (rcnt == 0) mode = 0;
            end
         default: if (bus.dismiss || !bus.alarm_en[aidx]) mode = 0;
            else if (bus.sec_tick) begin
               scnt--;
               if (scnt == 0) begin mode = 1; rcnt = RS; blink = 1; end
            end
      endcase
      sel = int'(bus.load_sel);
      bad = sel >= NA || bus.load_min0 > 9 || bus.load_sec0 > 9 || bus.load_min1 > 5 || bus.load_sec1 > 5;
      lerr = bus.load_en && bad;
      if (bus.load_en && !bad)
         set_s[sel] = (int'(bus.load_min1) * 10 + int'(bus.load_min0)) * 60 +
                      int'(bus.load_sec1) * 10 + int'(bus.load_sec0);
   endtask

   task automatic step();
      exp_t e;
      if (!rst_n) model_reset(); else model_step();
      e.ringing  = mode == 1;
      e.snoozing = mode == 2;
      e.led      = mode == 1 ? (blink ? {LW{1'b1}} : '0) : (mode == 2 ? LW'(1) : '0);
      e.idx      = 2'(aidx);
      e.err      = lerr;
      e.rd       = bcd(set_s[bus.rd_sel]);
      sbq.push_back(e);
      @(posedge clk);
      #4;
      bus.sec_tick = 0; bus.load_en = 0; bus.snooze = 0; bus.dismiss = 0;
   endtask

   task automatic drive_time();
      {bus.time_min1, bus.time_min0, bus.time_sec1, bus.time_sec0} = bcd(cur);
   endtask

   task automatic set_time(int t);
      cur = t;
      drive_time();
      step();
   endtask

   task automatic tick(bit advance);
      if (advance) cur = (cur + 1) % 3600;
      drive_time();
      bus.sec_tick = 1;
      step(); step(); step();
   endtask

   task automatic load(int sel, int m1, int m0, int s1, int s0);
      bus.load_sel = 2'(sel); bus.rd_sel = 2'(sel);
      {bus.load_min1, bus.load_min0, bus.load_sec1, bus.load_sec0} = {4'(m1), 4'(m0), 4'(s1), 4'(s0)};
      bus.load_en = 1;
      step(); step();
   endtask

   // Asynchronous pulse entirely between clock edges.
   task automatic areset();
      rst_n = 0;
      #2;
      rst_n = 1;
      model_reset();
   endtask

   initial begin
      bus.sec_tick = 0; bus.alarm_en = '0; bus.load_en = 0; bus.load_sel = '0;
      {bus.load_min1, bus.load_min0, bus.load_sec1, bus.load_sec0} = '0;
      bus.rd_sel = '0; bus.snooze = 0; bus.dismiss = 0;
      cur = 0;
      drive_time();
      model_reset();
      step(); step();
      rst_n = 1;
      step();
      // ch2 rings at 01:30, blinks, then times out; held match does not retrigger
      load(2, 0, 1, 3, 0);
      bus.alarm_en = 4'b0100;
      set_time(87);
      repeat (3) tick(1);
      repeat (5) tick(0);
      // ring again, snooze, re-ring after the snooze period, dismiss
      set_time(200);
      set_time(89);
      tick(1);
      bus.snooze = 1; step();
      bus.snooze = 1; step();
      repeat (SS) tick(1);
      tick(1);
      bus.dismiss = 1; step(); step();
      // lowest index wins; later match on ch1 ignored while ringing
      load(0, 0, 0, 1, 0);
      load(3, 0, 0, 1, 0);
      load(1, 0, 0, 1, 1);
      bus.alarm_en = 4'b1011;
      set_time(9);
      tick(1);
      tick(1);
      bus.dismiss = 1; step();
      // rejected loads leave the setting untouched; 59:59 is the largest legal value
      load(1, 6, 0, 0, 0);
      load(1, 0, 0, 0, 10);
      load(2, 5, 9, 5, 9);
      load(2, 0, 10, 0, 0);
      load(2, 0, 9, 6, 0);
      // reset mid-snooze clears settings and state
      bus.alarm_en = 4'b0100;
      set_time(3598);
      tick(1);
      bus.snooze = 1; step();
      tick(1);
      areset();
      for (int i = 0; i < NA; i++) begin bus.rd_sel = 2'(i); step(); end
      // same-cycle snooze and dismiss go to idle
      load(0, 0, 0, 0, 5);
      bus.alarm_en = 4'b0001;
      set_time(4);
      tick(1);
      bus.snooze = 1; bus.dismiss = 1; step(); step();
      // random traffic
      for (int n = 0; n < 2000; n++) begin
         int r = int'($urandom_range(0, 99));
         if (r < 6) begin
            bus.load_sel = 2'($urandom_range(0, NA - 1));
            bus.load_min1 = 4'($urandom_range(0, 6)); bus.load_min0 = 4'($urandom_range(0, 10));
            bus.load_sec1 = 4'($urandom_range(0, 6)); bus.load_sec0 = 4'($urandom_range(0, 10));
            bus.load_en = 1;
         end
         if (r >= 6 && r < 9) bus.alarm_en = 4'($urandom_range(0, 15));
         if (r >= 9 && r < 13) begin
            cur = (set_s[$urandom_range(0, NA - 1)] + 3600 - int'($urandom_range(0, 2))) % 3600;
            drive_time();
         end
         if (r >= 13 && r < 16) bus.snooze = 1;
         if (r == 16) bus.dismiss = 1;
         if (r == 17) areset();
         if (r >= 60) begin
            cur = (cur + 1) % 3600;
            drive_time();
            bus.sec_tick = 1;
         end
         bus.rd_sel = 2'($urandom_range(0, NA - 1));
         step();
      end
      step();
      @(posedge clk);
      #4;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
